// File: rtl/reg32_rdsnap.sv
// Coherent 16-bit read port for a 32-bit register: the first half-word read
// snapshots the full value, the partner half is served from that snapshot.
module reg32_rdsnap #(
  parameter int WAIT_STATES = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [31:0] src_q,
  input  logic        rd_req,
  input  logic        rd_hi,
  input  logic        ovr_clr,
  output logic [15:0] rd_data,
  output logic        rd_ack,
  output logic        busy,
  output logic        held,
  output logic        overrun,
  output logic [0:0]  dbg_state
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT);
  localparam logic [2:0]    WAIT_LOAD = 3'(WAIT_STATES);

  logic [0:0]    state_q, state_d;
  logic          busy_q, busy_d;
  logic          sel_q, sel_d;
  logic          first_sel_q, first_sel_d;
  logic [31:0]   snap_q, snap_d;
  logic [2:0]    wait_q, wait_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   data_q, data_d;
  logic          ack_q, ack_d;
  logic          ovr_q, ovr_d;
  logic          accept;

  // Handshake: rd_req is taken only when busy=0; exactly one rd_ack pulse
  // follows each taken request, and busy falls in that same ack cycle.
  assign accept = rd_req & ~busy_q;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    sel_d       = sel_q;
    first_sel_d = first_sel_q;
    snap_d      = snap_q;
    wait_d      = wait_q;
    tmo_d       = tmo_q;
    data_d      = data_q;
    ack_d       = 1'b0;
    ovr_d       = ovr_q;

    if (busy_q) begin
      if (wait_q == 3'd0) begin
        ack_d  = 1'b1;
        busy_d = 1'b0;
        data_d = sel_q ? snap_q[31:16] : snap_q[15:0];
      end else begin
        wait_d = wait_q - 3'd1;
      end
    end

    if (accept) begin
      sel_d  = rd_hi;
      busy_d = 1'b1;
      wait_d = WAIT_LOAD;
      if (state_q == ST_HELD && rd_hi != first_sel_q) begin
        state_d = ST_IDLE;
      end else begin
        // A repeat of the first half is a fresh first read; first_sel sticks.
        snap_d  = src_q;
        tmo_d   = TMO_LOAD;
        state_d = ST_HELD;
        if (state_q == ST_IDLE) first_sel_d = rd_hi;
      end
    end else if (state_q == ST_HELD && TIMEOUT != 0) begin
      if (tmo_q == '0) state_d = ST_IDLE;
      else             tmo_d   = tmo_q - TW'(1);
    end

    if (rd_req && busy_q) ovr_d = 1'b1;
    else if (ovr_clr)     ovr_d = 1'b0;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      sel_q       <= 1'b0;
      first_sel_q <= 1'b0;
      snap_q      <= '0;
      wait_q      <= '0;
      tmo_q       <= '0;
      data_q      <= '0;
      ack_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      sel_q       <= sel_d;
      first_sel_q <= first_sel_d;
      snap_q      <= snap_d;
      wait_q      <= wait_d;
      tmo_q       <= tmo_d;
      data_q      <= data_d;
      ack_q       <= ack_d;
      ovr_q       <= ovr_d;
    end
  end

  assign rd_data   = data_q;
  assign rd_ack    = ack_q;
  assign busy      = busy_q;
  assign held      = (state_q == ST_HELD);
  assign overrun   = ovr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_reg32_rdsnap.sv
// Bench for reg32_rdsnap: two instances (no wait/short timeout, wait states/no
// timeout) share stimulus; an event-time model feeds per-instance ack queues.
module tb_reg32_rdsnap;

  localparam int WS0 = 0;
  localparam int TO0 = 4;
  localparam int WS1 = 3;
  localparam int TO1 = 0;

  logic        sys_clk = 1'b0;
  logic        rst     = 1'b1;
  logic [31:0] src_q   = '0;
  logic        rd_req  = 1'b0;
  logic        rd_hi   = 1'b0;
  logic        ovr_clr = 1'b0;

  logic [15:0] rd_data [2];
  logic        rd_ack  [2];
  logic        busy    [2];
  logic        held    [2];
  logic        overrun [2];
  logic [0:0]  dbg     [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  reg32_rdsnap #(.WAIT_STATES(WS0), .TIMEOUT(TO0)) u0 (
    .sys_clk(sys_clk), .rst(rst), .src_q(src_q), .rd_req(rd_req),
    .rd_hi(rd_hi), .ovr_clr(ovr_clr), .rd_data(rd_data[0]),
    .rd_ack(rd_ack[0]), .busy(busy[0]), .held(held[0]),
    .overrun(overrun[0]), .dbg_state(dbg[0])
  );

  reg32_rdsnap #(.WAIT_STATES(WS1), .TIMEOUT(TO1)) u1 (
    .sys_clk(sys_clk), .rst(rst), .src_q(src_q), .rd_req(rd_req),
    .rd_hi(rd_hi), .ovr_clr(ovr_clr), .rd_data(rd_data[1]),
    .rd_ack(rd_ack[1]), .busy(busy[1]), .held(held[1]),
    .overrun(overrun[1]), .dbg_state(dbg[1])
  );

  // Scoreboard entries: {edge index of expected ack, expected half-word}
  logic [47:0] exp_q0[$];
  logic [47:0] exp_q1[$];

  function automatic int ws_of(input int k);
    return (k == 0) ? WS0 : WS1;
  endfunction

  function automatic int to_of(input int k);
    return (k == 0) ? TO0 : TO1;
  endfunction

  function automatic int q_size(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [47:0] q_front(input int k);
    return (k == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  function automatic logic [47:0] q_pop(input int k);
    if (k == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  task automatic check(input string name, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s u%0d: got %0h, expected %0h (t=%0t)", name, k, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input int k,
                          input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    n_err++;
    $display("FAIL %s u%0d: got %0h, expected %0h (t=%0t)", name, k, act, exp, $time);
  endtask

  // Reference model: tracks each instance by absolute edge times.
  int          ecnt = 0;
  bit          m_pend [2];
  bit          m_held [2];
  bit          m_first[2];
  bit          m_ovr  [2];
  int          m_ack_edge[2];
  int          m_exp_edge[2];
  logic [31:0] m_snap [2];

  initial begin
    bit          acc;
    logic [15:0] d;
    forever begin
      @(posedge sys_clk or posedge rst);
      if (rst) begin
        for (int k = 0; k < 2; k++) begin
          m_pend[k] = 0; m_held[k] = 0; m_first[k] = 0; m_ovr[k] = 0;
          m_ack_edge[k] = 0; m_exp_edge[k] = 0; m_snap[k] = '0;
        end
        exp_q0.delete();
        exp_q1.delete();
      end else begin
        for (int k = 0; k < 2; k++) begin
          acc = rd_req && !m_pend[k];
          if (rd_req && m_pend[k]) m_ovr[k] = 1;
          else if (ovr_clr)        m_ovr[k] = 0;
          if (m_pend[k] && ecnt == m_ack_edge[k]) m_pend[k] = 0;
          if (acc) begin
            if (m_held[k] && rd_hi != m_first[k]) begin
              m_held[k] = 0;
            end else begin
              m_snap[k] = src_q;
              if (!m_held[k]) m_first[k] = rd_hi;
              m_held[k] = 1;
              m_exp_edge[k] = ecnt + to_of(k) + 1;
            end
            d = rd_hi ? m_snap[k][31:16] : m_snap[k][15:0];
            m_pend[k] = 1;
            m_ack_edge[k] = ecnt + 1 + ws_of(k);
            if (k == 0) exp_q0.push_back({32'(m_ack_edge[k]), d});
            else        exp_q1.push_back({32'(m_ack_edge[k]), d});
          end else if (m_held[k] && to_of(k) != 0 && ecnt >= m_exp_edge[k]) begin
            m_held[k] = 0;
          end
        end
        ecnt++;
      end
    end
  end

  // Monitor: flags every cycle, acks popped against the expected queue.
  initial begin
    logic [47:0] e;
    forever begin
      @(negedge sys_clk);
      if (!rst) begin
        for (int k = 0; k < 2; k++) begin
          check("busy", k, 32'(busy[k]), 32'(m_pend[k]));
          check("held", k, 32'(held[k]), 32'(m_held[k]));
          check("overrun", k, 32'(overrun[k]), 32'(m_ovr[k]));
          if (q_size(k) > 0) begin
            e = q_front(k);
            if (int'(e[47:16]) < ecnt - 1) begin
              fail_now("ack_missing_by_edge", k, 32'(ecnt - 1), e[47:16]);
              e = q_pop(k);
            end
          end
          if (rd_ack[k]) begin
            if (q_size(k) == 0) begin
              fail_now("ack_unexpected", k, 32'(rd_data[k]), 32'd0);
            end else begin
              e = q_pop(k);
              check("ack_edge", k, 32'(ecnt - 1), e[47:16]);
              check("rd_data", k, 32'(rd_data[k]), 32'(e[15:0]));
            end
          end
        end
      end
    end
  end

  task automatic rd(input logic hi);
    rd_req = 1'b1;
    rd_hi  = hi;
    @(negedge sys_clk);
    rd_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic check_all_zero(input string name);
    for (int k = 0; k < 2; k++) begin
      check({name, "_rd_data"}, k, 32'(rd_data[k]), 32'd0);
      check({name, "_rd_ack"},  k, 32'(rd_ack[k]),  32'd0);
      check({name, "_busy"},    k, 32'(busy[k]),    32'd0);
      check({name, "_held"},    k, 32'(held[k]),    32'd0);
      check({name, "_overrun"}, k, 32'(overrun[k]), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle(2);
    check_all_zero("reset");
    rst = 1'b0;
    idle(2);

    // Tear-free pair, low half first, live value changing in between
    src_q = 32'h1234_5678; rd(1'b0);
    src_q = 32'hAAAA_5555; idle(4);
    rd(1'b1); idle(4);

    // Order reversal
    src_q = 32'hCAFE_BABE; rd(1'b1);
    src_q = 32'h0000_0000; idle(2);
    rd(1'b0); idle(6);
    ovr_clr = 1'b1; @(negedge sys_clk); ovr_clr = 1'b0;

    // Repeat of the same half re-snapshots
    src_q = 32'h0001_0002; rd(1'b0);
    src_q = 32'h0003_0004; idle(4);
    rd(1'b0); idle(4);
    rd(1'b1); idle(4);

    // Timeout expiry then a fresh snapshot
    src_q = 32'h1111_2222; rd(1'b0); idle(6);
    src_q = 32'hBEEF_0000; rd(1'b1); idle(4);
    rd(1'b0); idle(6);

    // Overrun set and clear in the same cycle: set wins
    rd(1'b0); idle(1);
    rd_req = 1'b1; ovr_clr = 1'b1; @(negedge sys_clk);
    rd_req = 1'b0; ovr_clr = 1'b0; idle(6);
    ovr_clr = 1'b1; @(negedge sys_clk); ovr_clr = 1'b0;

    // Reset while a request is in flight
    src_q = 32'h9999_8888; rd(1'b0); idle(1);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge sys_clk); rst = 1'b0;
    src_q = 32'h5566_7788; idle(6);
    rd(1'b1); idle(2);
    src_q = 32'h0;
    idle(4);
    rd(1'b0); idle(6);

    // Randomized traffic
    repeat (1500) begin
      src_q   = $urandom;
      rd_req  = ($urandom_range(0, 2) == 0);
      rd_hi   = 1'($urandom_range(0, 1));
      ovr_clr = ($urandom_range(0, 15) == 0);
      @(negedge sys_clk);
    end
    rd_req = 1'b0; ovr_clr = 1'b0;
    idle(12);
    #1;
    check("drain", 0, 32'(q_size(0)), 32'd0);
    check("drain", 1, 32'(q_size(1)), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
